// File: rtl/gun_pkg.sv
// Shared types and helpers for the light-gun position controller.
package gun_pkg;

    typedef enum logic [1:0] {
        GUN_IDLE,
        GUN_SLOW,
        GUN_FAST
    } gun_state_t;

    // Mid-scale coordinate for a given width.
    function automatic int unsigned gun_center(input int unsigned width);
        return 32'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/gun_position_ctrl_if.sv
// Joystick/pacing inputs and gun coordinate outputs of the position controller.
interface gun_position_ctrl_if #(
    parameter int unsigned GUN_W = 6
);
    logic             cnt_4ms;
    logic             m_left;
    logic             m_right;
    logic             m_up;
    logic             m_down;
    logic             m_center;
    logic [GUN_W-1:0] gun_h;
    logic [GUN_W-1:0] gun_v;
    logic             gun_moved;

    modport master (
        output cnt_4ms, m_left, m_right, m_up, m_down, m_center,
        input  gun_h, gun_v, gun_moved
    );

    modport slave (
        input  cnt_4ms, m_left, m_right, m_up, m_down, m_center,
        output gun_h, gun_v, gun_moved
    );
endinterface

// File: rtl/gun_axis.sv
// One coordinate axis: IDLE/SLOW/FAST acceleration FSM with a saturating
// position register. changed flags that pos_o updates on the coming edge.
module gun_axis
    import gun_pkg::*;
#(
    parameter int unsigned GUN_W      = 6,
    parameter int unsigned SLOW_DIV   = 4,
    parameter int unsigned FAST_DIV   = 1,
    parameter int unsigned ACCEL_HOLD = 8
) (
    input  logic             clock_12,
    input  logic             reset,
    input  logic             tick,
    input  logic             neg,
    input  logic             pos,
    input  logic             center,
    output logic [GUN_W-1:0] pos_o,
    output logic             changed
);

    localparam int unsigned DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int unsigned DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int unsigned HOLD_W  = $clog2(ACCEL_HOLD + 1);

    localparam logic [GUN_W-1:0]  CENTER   = GUN_W'(gun_center(GUN_W));
    localparam logic [GUN_W-1:0]  POS_MAX  = '1;
    localparam logic [DIV_W-1:0]  SLOW_TOP = DIV_W'(SLOW_DIV - 1);
    localparam logic [DIV_W-1:0]  FAST_TOP = DIV_W'(FAST_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(ACCEL_HOLD);

    gun_state_t        state_q, state_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [GUN_W-1:0]  pos_q,   pos_d;
    logic [HOLD_W-1:0] hold_inc;
    logic              step;

    always_ff @(posedge clock_12 or posedge reset) begin
        if (reset) begin
            state_q <= GUN_IDLE;
            div_q   <= '0;
            hold_q  <= '0;
            pos_q   <= CENTER;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            hold_q  <= hold_d;
            pos_q   <= pos_d;
        end
    end

    // Recentre overrides everything; otherwise the FSM only moves on a tick.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        hold_d   = hold_q;
        pos_d    = pos_q;
        step     = 1'b0;
        hold_inc = hold_q + HOLD_W'(1);

        if (center) begin
            state_d = GUN_IDLE;
            div_d   = '0;
            hold_d  = '0;
            pos_d   = CENTER;
        end else if (tick) begin
            if (neg == pos) begin
                state_d = GUN_IDLE;
                div_d   = '0;
                hold_d  = '0;
            end else begin
                unique case (state_q)
                    GUN_IDLE: begin
                        step    = 1'b1;
                        state_d = GUN_SLOW;
                        div_d   = '0;
                        hold_d  = '0;
                    end
                    GUN_SLOW: begin
                        if (div_q == SLOW_TOP) begin
                            step   = 1'b1;
                            div_d  = '0;
                            hold_d = hold_inc;
                            if (hold_inc == HOLD_TOP) begin
                                state_d = GUN_FAST;
                            end
                        end else begin
                            div_d = div_q + DIV_W'(1);
                        end
                    end
                    GUN_FAST: begin
                        if (div_q == FAST_TOP) begin
                            step  = 1'b1;
                            div_d = '0;
                        end else begin
                            div_d = div_q + DIV_W'(1);
                        end
                    end
                    default: begin
                        state_d = GUN_IDLE;
                        div_d   = '0;
                        hold_d  = '0;
                    end
                endcase

                // Steps past either end are dropped; counters keep advancing.
                if (step) begin
                    if (pos && (pos_q != POS_MAX)) begin
                        pos_d = pos_q + GUN_W'(1);
                    end else if (neg && (pos_q != '0)) begin
                        pos_d = pos_q - GUN_W'(1);
                    end
                end
            end
        end
    end

    assign pos_o   = pos_q;
    assign changed = (pos_d != pos_q);

endmodule

// File: rtl/gun_position_ctrl.sv
// Joystick-to-light-gun coordinate integrator: tick edge detector, two axis
// integrators, and the registered movement pulse.
module gun_position_ctrl
    import gun_pkg::*;
#(
    parameter int unsigned GUN_W      = 6,
    parameter int unsigned SLOW_DIV   = 4,
    parameter int unsigned FAST_DIV   = 1,
    parameter int unsigned ACCEL_HOLD = 8
) (
    input  logic                clock_12,
    input  logic                reset,
    gun_position_ctrl_if.slave  bus
);

    logic             cnt_4ms_d;
    logic             tick;
    logic             h_changed;
    logic             v_changed;
    logic             gun_moved_q;
    logic [GUN_W-1:0] h_pos;
    logic [GUN_W-1:0] v_pos;

    // One tick per rising edge of the pacing strobe.
    assign tick = bus.cnt_4ms & ~cnt_4ms_d;

    always_ff @(posedge clock_12 or posedge reset) begin
        if (reset) begin
            cnt_4ms_d   <= 1'b0;
            gun_moved_q <= 1'b0;
        end else begin
            cnt_4ms_d   <= bus.cnt_4ms;
            gun_moved_q <= h_changed | v_changed;
        end
    end

    gun_axis #(
        .GUN_W      (GUN_W),
        .SLOW_DIV   (SLOW_DIV),
        .FAST_DIV   (FAST_DIV),
        .ACCEL_HOLD (ACCEL_HOLD)
    ) u_axis_h (
        .clock_12 (clock_12),
        .reset    (reset),
        .tick     (tick),
        .neg      (bus.m_left),
        .pos      (bus.m_right),
        .center   (bus.m_center),
        .pos_o    (h_pos),
        .changed  (h_changed)
    );

    gun_axis #(
        .GUN_W      (GUN_W),
        .SLOW_DIV   (SLOW_DIV),
        .FAST_DIV   (FAST_DIV),
        .ACCEL_HOLD (ACCEL_HOLD)
    ) u_axis_v (
        .clock_12 (clock_12),
        .reset    (reset),
        .tick     (tick),
        .neg      (bus.m_up),
        .pos      (bus.m_down),
        .center   (bus.m_center),
        .pos_o    (v_pos),
        .changed  (v_changed)
    );

    assign bus.gun_h     = h_pos;
    assign bus.gun_v     = v_pos;
    assign bus.gun_moved = gun_moved_q;

endmodule

// File: doc/gun_position_ctrl.md
# gun_position_ctrl

Converts the four digital joystick directions into the 6-bit horizontal and vertical light-gun coordinates consumed by the `williams2` core's `gun_h` / `gun_v` inputs. Movement is paced by the core's `cnt_4ms_o` strobe, with a slow-then-fast acceleration profile and saturation at both ends of each axis. It sits between the joystick decode in the top level and `williams2`, and replaces the ad-hoc inline integrator.

## Interface
Parameters:
- `GUN_W`, 6: coordinate width. Range 0..2^GUN_W-1; centre is 2^(GUN_W-1).
- `SLOW_DIV`, 4: ticks per step in SLOW state (≥1).
- `FAST_DIV`, 1: ticks per step in FAST state (≥1).
- `ACCEL_HOLD`, 8: number of SLOW steps before entering FAST (≥1).

Ports:
- `clock_12`, in, 1: system clock; all logic is on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `cnt_4ms`, in, 1: pacing strobe from `williams2`. Its rising edge is one tick.
- `m_left`, `m_right`, `m_up`, `m_down`, in, 1 each: active-high directions, synchronous to `clock_12`.
- `m_center`, in, 1: synchronous recentre request, active-high.
- `gun_h`, out, GUN_W: horizontal coordinate, registered.
- `gun_v`, out, GUN_W: vertical coordinate, registered.
- `gun_moved`, out, 1: one-cycle pulse when either coordinate changed on the previous edge.

## Operation
- Tick detection: `cnt_4ms_d` is registered. `tick = cnt_4ms & ~cnt_4ms_d`.
- Each axis is independent. Horizontal: left = −1, right = +1. Vertical: up = −1, down = +1.
- An axis is active when exactly one of its two directions is high. Both high or neither high means inactive.
- Per-axis FSM states are IDLE, SLOW and FAST. Each axis also has a divider `div` (clog2 of the max divider) and a hold counter `hold` (clog2(ACCEL_HOLD+1)).
- FSM transitions, evaluated only on a tick cycle:
  - Inactive in any state: go to IDLE, clear `div` and `hold`, no step.
  - IDLE and active: step once immediately, go to SLOW, `div` = 0, `hold` = 0.
  - SLOW and active: if `div == SLOW_DIV-1`, step, set `div` = 0 and increment `hold`. If that increment makes `hold` reach ACCEL_HOLD, go to FAST. Otherwise `div`++.
  - FAST and active: if `div == FAST_DIV-1`, step and set `div` = 0. Otherwise `div`++.
  - Reversing direction while active does not reset the state; the next step simply takes the new sign.
- Saturation: a step below 0 or above 2^GUN_W-1 leaves the coordinate unchanged. The divider and hold counters still advance normally.
- Recentre: `m_center` has priority over ticks. On any cycle where it is high, both coordinates are set to centre, both FSMs go to IDLE, and both counters clear.
- `gun_moved` is registered. It is 1 in the cycle after either coordinate changed value; a saturated step or a recentre from centre produces no pulse.
- Reset values: `gun_h` = `gun_v` = centre (32), FSMs IDLE, counters 0, `cnt_4ms_d` = 0, `gun_moved` = 0.

## Timing
- Latency: if `cnt_4ms` is first seen high at edge N, `tick` is high during the following cycle. The coordinate update is captured at edge N+1 and visible after it.
- At most one step per axis per tick. Non-tick cycles never change coordinates except through recentre.
- A held-high `cnt_4ms` produces only one tick.
- Direction inputs are sampled only in tick cycles; pulses between ticks are ignored.
- Asynchronous reset during a hold takes effect immediately, with no partial step.
- Recentre in the same cycle as a tick wins: result is centre, state IDLE.

## Structure
- Package `gun_pkg` holds:
  - `typedef enum logic [1:0] {GUN_IDLE, GUN_SLOW, GUN_FAST} gun_state_t`
  - function `gun_center(width)`
- Sub-module `gun_axis`, instantiated twice. Its ports are `clock_12`, `reset`, `tick`, `neg`, `pos`, `center`, `pos_o`, `changed`, and it takes the same parameters. The top module contains the tick detector and the `gun_moved` OR-register.

## Test plan
All scenarios use default parameters with a tick every 16 cycles.
1. Reset, then hold `m_right`: tick 1 → `gun_h` = 33; tick 5 → 34; tick 33 → 41 (FAST entered); tick 34 → 42; tick 55 → 63; tick 60 → still 63, with no `gun_moved` pulse after 63.
2. Reset, then hold `m_up` for 200 ticks: `gun_v` saturates at 0 and stays there; `gun_h` stays 32 throughout.
3. Hold `m_left` and `m_right` together for 10 ticks: `gun_h` stays 32, FSM stays IDLE. Release `m_right`: the next tick gives 31.
4. Hold `m_down` to reach FAST (`gun_v` = 41), then pulse `m_center` for 1 cycle coincident with a tick: `gun_v` = 32. The next tick with `m_down` held gives 33, a single step from IDLE.
5. Hold `cnt_4ms` high for 100 cycles with `m_right` held: exactly one step. `gun_moved` is high for exactly 1 cycle, the cycle after the update.
6. Assert `reset` asynchronously mid-hold at `gun_h` = 45: the outputs read 32 immediately, before the next clock edge.
